tl_sensor_cond: RTL and testbench

- Upstream stage of the traffic-light next-state logic. Turns the raw, noisy, asynchronous car-presence detectors for street A and street B into the clean Ta/Tb traffic flags that the next-state decision consumes.
- Synchronizes and debounces each detector on a slow time-base tick.
- Enforces a minimum green time by holding the serving street's flag high after each green entry.
- Takes the current 2-bit light state as input, so it knows which street is green.

---
 rtl/tl_sensor_cond_if.sv | 28 ++
 rtl/tl_sensor_cond.sv | 108 ++++++++++
 tb/tb_tl_sensor_cond.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/tl_sensor_cond_if.sv
`default_nettype none
// ============================================================================
// Module      : tl_sensor_cond_if
// Description : Detector inputs, light state and conditioned traffic flags
//               exchanged with the traffic-light sensor conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
interface tl_sensor_cond_if;
    logic       tick;
    logic       raw_a;
    logic       raw_b;
    logic [1:0] q;
    logic       Ta;
    logic       Tb;
    logic       deb_a;
    logic       deb_b;

    modport master (
        output tick, raw_a, raw_b, q,
        input  Ta, Tb, deb_a, deb_b
    );

    modport slave (
        input  tick, raw_a, raw_b, q,
        output Ta, Tb, deb_a, deb_b
    );
endinterface
`default_nettype wire

// File: rtl/tl_sensor_cond.sv
`default_nettype none
// ============================================================================
// Module      : tl_sensor_cond
// Description : Synchronizes and debounces the street A/B car detectors and
//               applies a minimum-green hold to produce registered Ta/Tb.
//               Optional max-green cut enabled by TL_SENSOR_MAXGREEN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_sensor_cond #(
    parameter int unsigned DB_TICKS  = 3,
    parameter int unsigned MIN_GREEN = 5,
    parameter int unsigned MAX_GREEN = 20
) (
    input  logic            clk,
    input  logic            reset_n,
    tl_sensor_cond_if.slave bus
);

    localparam logic [7:0] c_db_ticks  = 8'(DB_TICKS);
    localparam logic [7:0] c_min_green = 8'(MIN_GREEN);
    localparam logic [7:0] c_max_green = 8'(MAX_GREEN);
    localparam logic [1:0] c_q_a_green = 2'b00;
    localparam logic [1:0] c_q_b_green = 2'b10;
`ifdef TL_SENSOR_MAXGREEN_EN
    localparam bit         c_max_en    = 1'b1;
`else
    localparam bit         c_max_en    = 1'b0;
`endif

    logic [1:0] w_raw;
    logic [1:0] w_deb;

    assign w_raw = {bus.raw_b, bus.raw_a};

    // Channel 0 is street A, channel 1 is street B.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_chan
        logic [1:0] r_sync;
        logic       r_deb;
        logic [7:0] r_dbc;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_sync <= 2'b00;
                r_deb  <= 1'b0;
                r_dbc  <= 8'd0;
            end else begin
                r_sync <= {r_sync[0], w_raw[gi]};
                if (r_sync[1] == r_deb) begin
                    r_dbc <= 8'd0;
                end else if (bus.tick) begin
                    if (r_dbc + 8'd1 == c_db_ticks) begin
                        r_deb <= ~r_deb;
                        r_dbc <= 8'd0;
                    end else begin
                        r_dbc <= r_dbc + 8'd1;
                    end
                end
            end
        end

        assign w_deb[gi] = r_deb;
    end

    logic [1:0] r_q_prev;
    logic [7:0] r_gcnt;
    logic       r_ta;
    logic       r_tb;
    logic       w_green_entry;
    logic       w_hold;
    logic       w_cut_a;
    logic       w_cut_b;

    assign w_green_entry = (bus.q != r_q_prev) &&
                           ((bus.q == c_q_a_green) || (bus.q == c_q_b_green));
    assign w_hold        = (r_gcnt < c_min_green);

    // Max-green cut: drop the serving flag once the other street is waiting.
    assign w_cut_a = c_max_en && (bus.q == c_q_a_green) &&
                     (r_gcnt >= c_max_green) && w_deb[1];
    assign w_cut_b = c_max_en && (bus.q == c_q_b_green) &&
                     (r_gcnt >= c_max_green) && w_deb[0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q_prev <= 2'b00;
            r_gcnt   <= 8'd0;
            r_ta     <= 1'b0;
            r_tb     <= 1'b0;
        end else begin
            r_q_prev <= bus.q;
            if (w_green_entry) begin
                r_gcnt <= 8'd0;
            end else if (bus.tick && (r_gcnt != 8'hFF)) begin
                r_gcnt <= r_gcnt + 8'd1;
            end
            r_ta <= (w_deb[0] | ((bus.q == c_q_a_green) & w_hold)) & ~w_cut_a;
            r_tb <= (w_deb[1] | ((bus.q == c_q_b_green) & w_hold)) & ~w_cut_b;
        end
    end

    assign bus.Ta    = r_ta;
    assign bus.Tb    = r_tb;
    assign bus.deb_a = w_deb[0];
    assign bus.deb_b = w_deb[1];

endmodule
`default_nettype wire

// File: tb/tb_tl_sensor_cond.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl_sensor_cond
// Description : Directed self-checking bench for tl_sensor_cond.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_sensor_cond;

    logic clk = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;

`ifdef TL_SENSOR_MAXGREEN_EN
    localparam logic c_ta_after_max = 1'b0;
`else
    localparam logic c_ta_after_max = 1'b1;
`endif

    tl_sensor_cond_if bus ();

    tl_sensor_cond #(
        .DB_TICKS  (3),
        .MIN_GREEN (5),
        .MAX_GREEN (20)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", tag, got, exp);
        end
    endtask

    // One clk edge with the given tick level; returns at the following negedge.
    task automatic cyc(input logic t);
        bus.tick = t;
        @(negedge clk);
        bus.tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0);
    endtask

    task automatic tick_grp();
        cyc(1'b1);
        idle(3);
    endtask

    initial begin
        reset_n   = 1'b0;
        bus.tick  = 1'b0;
        bus.raw_a = 1'b0;
        bus.raw_b = 1'b0;
        bus.q     = 2'b00;
        @(negedge clk);
        idle(3);
        check_val("rst_ta",    bus.Ta,    1'b0);
        check_val("rst_tb",    bus.Tb,    1'b0);
        check_val("rst_deb_a", bus.deb_a, 1'b0);
        check_val("rst_deb_b", bus.deb_b, 1'b0);

        // Minimum green hold on A straight out of reset
        reset_n = 1'b1;
        cyc(1'b0);
        check_val("t1_hold_start", bus.Ta, 1'b1);
        idle(3);
        for (int i = 1; i <= 5; i++) begin
            tick_grp();
            check_val("t1_ta_hold", bus.Ta, (i < 5) ? 1'b1 : 1'b0);
            check_val("t1_tb_low",  bus.Tb, 1'b0);
        end

        // Glitch lasting only two ticks is rejected
        bus.raw_a = 1'b1;
        idle(2);
        tick_grp();
        tick_grp();
        bus.raw_a = 1'b0;
        idle(4);
        check_val("t2_glitch_deb", bus.deb_a, 1'b0);
        tick_grp();
        tick_grp();
        tick_grp();
        check_val("t2_glitch_deb2", bus.deb_a, 1'b0);
        check_val("t2_glitch_ta",   bus.Ta,    1'b0);

        // Held input sets deb_a on the third tick, Ta one clk later
        bus.raw_a = 1'b1;
        idle(2);
        tick_grp();
        tick_grp();
        check_val("t2_deb_pre", bus.deb_a, 1'b0);
        cyc(1'b1);
        check_val("t2_deb_set", bus.deb_a, 1'b1);
        check_val("t2_ta_lag",  bus.Ta,    1'b0);
        cyc(1'b0);
        check_val("t2_ta_set",  bus.Ta,    1'b1);
        idle(2);

        // Release A and debounce back to 0
        bus.raw_a = 1'b0;
        idle(2);
        tick_grp();
        tick_grp();
        check_val("t2_fall_pre", bus.deb_a, 1'b1);
        cyc(1'b1);
        check_val("t2_fall", bus.deb_a, 1'b0);
        idle(3);
        check_val("t2_fall_ta", bus.Ta, 1'b0);

        // A yellow then B green entry
        bus.q = 2'b01;
        cyc(1'b0);
        check_val("t3_yel_tb", bus.Tb, 1'b0);
        tick_grp();
        tick_grp();
        check_val("t3_yel_tb2", bus.Tb, 1'b0);
        bus.q = 2'b10;
        cyc(1'b0);
        cyc(1'b0);
        check_val("t3_entry_tb", bus.Tb, 1'b1);
        idle(2);
        for (int i = 1; i <= 5; i++) begin
            tick_grp();
            check_val("t3_tb_hold", bus.Tb, (i < 5) ? 1'b1 : 1'b0);
            check_val("t3_ta_low",  bus.Ta, 1'b0);
        end

        // Green entry on the same clk as a tick: clear wins
        bus.q = 2'b11;
        cyc(1'b0);
        check_val("t5_yel_tb", bus.Tb, 1'b0);
        bus.q = 2'b00;
        cyc(1'b1);
        idle(3);
        check_val("t5_entry_ta", bus.Ta, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            tick_grp();
            check_val("t5_ta_hold", bus.Ta, (i < 5) ? 1'b1 : 1'b0);
        end

        // Reset in the middle of a debounce count
        bus.raw_b = 1'b1;
        idle(2);
        tick_grp();
        tick_grp();
        tick_grp();
        check_val("t4_deb_b", bus.deb_b, 1'b1);
        check_val("t4_tb",    bus.Tb,    1'b1);
        bus.raw_a = 1'b1;
        idle(2);
        tick_grp();
        tick_grp();
        check_val("t4_mid_deb_a", bus.deb_a, 1'b0);
        reset_n = 1'b0;
        cyc(1'b1);
        check_val("t4_rst_ta",    bus.Ta,    1'b0);
        check_val("t4_rst_tb",    bus.Tb,    1'b0);
        check_val("t4_rst_deb_a", bus.deb_a, 1'b0);
        check_val("t4_rst_deb_b", bus.deb_b, 1'b0);
        reset_n = 1'b1;
        idle(2);
        tick_grp();
        tick_grp();
        check_val("t4_restart_a", bus.deb_a, 1'b0);
        check_val("t4_restart_b", bus.deb_b, 1'b0);
        cyc(1'b1);
        check_val("t4_set_a", bus.deb_a, 1'b1);
        check_val("t4_set_b", bus.deb_b, 1'b1);
        idle(3);
        check_val("t4_ta", bus.Ta, 1'b1);
        check_val("t4_tb", bus.Tb, 1'b1);

        // Long A green with demand on both streets
        bus.q = 2'b01;
        cyc(1'b0);
        bus.q = 2'b00;
        cyc(1'b0);
        idle(2);
        for (int i = 1; i <= 19; i++) tick_grp();
        check_val("t6_pre_ta", bus.Ta, 1'b1);
        cyc(1'b1);
        check_val("t6_at_ta", bus.Ta, 1'b1);
        cyc(1'b0);
        check_val("t6_max_ta", bus.Ta, c_ta_after_max);
        check_val("t6_max_tb", bus.Tb, 1'b1);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
